fangwen: RTL and testbench

- Dual fixed-frequency square-wave generator for the 2FSK demodulator path.
- Produces two 11-bit amplitude square waves, dout1 at the mark frequency and dout2 at the space frequency, for downstream correlation/filter stages.
- Frequencies are set by half-period parameters counted in clk cycles. Fully synchronous, single clock domain.

---
 rtl/fangwen_pkg.sv | 24 ++
 rtl/fangwen_sqgen.sv | 55 +++++
 rtl/fangwen.sv | 34 +++
 tb/tb_fangwen.sv | 102 ++++++++++
 4 files changed

// File: rtl/fangwen_pkg.sv
// Shared types and level-to-sample mapping for the fangwen square-wave generator.
// Macro FANGWEN_BIPOLAR_EN selects a +/-AMP output instead of AMP/0.
package fangwen_pkg;

    localparam int DW = 11;

    typedef logic [DW-1:0] word_t;

`ifdef FANGWEN_BIPOLAR_EN
    localparam int unsigned AMP_MAX = 1023;
`else
    localparam int unsigned AMP_MAX = 2047;
`endif

    // LOW maps to -AMP in two's complement when bipolar, else to zero.
    function automatic word_t level_to_sample(input logic level, input word_t amp);
`ifdef FANGWEN_BIPOLAR_EN
        return level ? amp : (word_t'(0) - amp);
`else
        return level ? amp : word_t'(0);
`endif
    endfunction

endpackage

// File: rtl/fangwen_sqgen.sv
// One square-wave channel: half-period counter, level bit and registered sample.
// Output mapping follows FANGWEN_BIPOLAR_EN through fangwen_pkg.
module fangwen_sqgen
    import fangwen_pkg::*;
#(
    parameter int          HALF = 25,
    parameter int unsigned AMP  = 11'h3FF
) (
    input  logic          clk,
    input  logic          rst,
    output logic [DW-1:0] dout
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST  = CW'(HALF - 1);
    localparam word_t         AMP_W = DW'(AMP);

    if (HALF < 1) begin : g_bad_half
        $fatal(1, "fangwen_sqgen: HALF must be >= 1");
    end
    if (AMP > AMP_MAX) begin : g_bad_amp
        $fatal(1, "fangwen_sqgen: AMP out of range");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;
    word_t         dout_q;

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        level_d = level_q;
        if (cnt_q == LAST) begin
            cnt_d   = '0;
            level_d = ~level_q;
        end
    end

    // The output is mapped from the next level so it changes on the toggle edge itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            dout_q  <= level_to_sample(level_d, AMP_W);
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/fangwen.sv
// Dual fixed-frequency square-wave generator (mark on dout1, space on dout2).
// Build with FANGWEN_BIPOLAR_EN for +/-AMP outputs; default is AMP/0.
module fangwen
    import fangwen_pkg::*;
#(
    parameter int          HALF1 = 25,
    parameter int          HALF2 = 50,
    parameter int unsigned AMP   = 11'h3FF
) (
    input  logic          clk,
    input  logic          rst,
    output logic [DW-1:0] dout1,
    output logic [DW-1:0] dout2
);

    fangwen_sqgen #(
        .HALF (HALF1),
        .AMP  (AMP)
    ) u_mark (
        .clk  (clk),
        .rst  (rst),
        .dout (dout1)
    );

    fangwen_sqgen #(
        .HALF (HALF2),
        .AMP  (AMP)
    ) u_space (
        .clk  (clk),
        .rst  (rst),
        .dout (dout2)
    );

endmodule

// File: tb/tb_fangwen.sv
// Self-checking bench for fangwen: three parameterisations driven from one reset,
// compared every edge against an edge-count model of the square waves.
module tb_fangwen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Instances: defaults, short halves, and HALF1=1 with a non-trivial amplitude.
    localparam int NCH = 6;
    localparam int          HALF_T [NCH] = '{25, 50, 2, 3, 1, 3};
    localparam logic [10:0] AMP_T  [NCH] = '{11'h3FF, 11'h3FF, 11'h3FF, 11'h3FF, 11'h155, 11'h155};

    logic [10:0] dout [NCH];

    fangwen u_def (
        .clk   (clk),
        .rst   (rst),
        .dout1 (dout[0]),
        .dout2 (dout[1])
    );

    fangwen #(.HALF1(2), .HALF2(3)) u_short (
        .clk   (clk),
        .rst   (rst),
        .dout1 (dout[2]),
        .dout2 (dout[3])
    );

    fangwen #(.HALF1(1), .HALF2(3), .AMP(11'h155)) u_fast (
        .clk   (clk),
        .rst   (rst),
        .dout1 (dout[4]),
        .dout2 (dout[5])
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected sample after n non-reset edges since the last reset edge.
    function automatic logic [10:0] model_val(input int n, input int half, input logic [10:0] amp);
        logic [10:0] lo;
`ifdef FANGWEN_BIPOLAR_EN
        lo = 11'd0 - amp;
`else
        lo = 11'd0;
`endif
        if (n == 0) return 11'd0;
        return (((n / half) % 2) == 1) ? amp : lo;
    endfunction

    int n_edges = 0;

    task automatic step_and_check(input logic rst_v, input string phase);
        @(negedge clk);
        rst = rst_v;
        @(posedge clk);
        if (rst_v) n_edges = 0;
        else       n_edges++;
        #1;
        for (int c = 0; c < NCH; c++) begin
            check_val($sformatf("%s_ch%0d_n%0d", phase, c, n_edges), dout[c],
                      model_val(n_edges, HALF_T[c], AMP_T[c]));
        end
    endtask

    initial begin
        // Reset hold: outputs stay zero throughout.
        for (int i = 0; i < 3; i++) step_and_check(1'b1, "rsthold");
        $display("phase reset-hold done checks=%0d", checks);

        // Free run long enough for many default-length periods.
        for (int i = 0; i < 1200; i++) step_and_check(1'b0, "run");
        $display("phase long-run done checks=%0d", checks);

        // Directed mid-period reset while the HALF1=2 channel is high.
        step_and_check(1'b1, "midrst");
        step_and_check(1'b0, "midrst");
        step_and_check(1'b0, "midrst");
        step_and_check(1'b1, "midrst");
        for (int i = 0; i < 12; i++) step_and_check(1'b0, "midrst");
        $display("phase mid-reset done checks=%0d", checks);

        // Random resets at arbitrary phases.
        for (int i = 0; i < 800; i++)
            step_and_check(($urandom_range(0, 29) == 0), "rand");
        $display("phase random-reset done checks=%0d", checks);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
